instruction_decode: RTL and testbench

- Second stage of the basic ARM 5-stage pipeline.
- Consumes pc_out/instruction from the fetch stage and decodes the 32-bit ARM word.
- Reads the register file, which is written back from the WB stage, and evaluates the condition field against the status register.
- Drives the ID/EX pipeline register and the combinational source indications used by the hazard unit.

---
 rtl/instruction_decode.sv | 267 ++++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// Second stage of a 5-stage ARM pipeline. Decodes the fetched 32-bit word,
// reads the register file (written back from WB), checks the condition field
// against NZCV and drives the ID/EX pipeline register. It also presents
// combinational source indices for the hazard unit.
//
// Build option:
//   ID_NEGEDGE_WB_EN - register file writes on the falling clock edge and the
//                      same-cycle bypass is removed. The half-cycle
//                      write-before-read gives the same visible result.
//                      Undefined (default): rising-edge write plus bypass.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   freeze, flush      stall bubble / kill the instruction in decode
//   pc_in, instruction PC+4 and instruction word from fetch
//   wb_en, wb_dest,
//   wb_value           register file writeback
//   status             NZCV flags
//   pc_out .. b_out    registered ID/EX fields
//   src1, src2,
//   two_src            combinational source indications (never gated)
// -----------------------------------------------------------------------------
module instruction_decode #(
    parameter int REG_COUNT = 15,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [31:0]       instruction,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [3:0]        status,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [3:0]        dest,
    output logic [11:0]       shift_operand,
    output logic              imm,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        exe_cmd,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en_out,
    output logic              s_out,
    output logic              b_out,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src
);

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // ARM condition evaluation; 1111 is treated as never.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic ok;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: ok = z;
            4'b0001: ok = !z;
            4'b0010: ok = c;
            4'b0011: ok = !c;
            4'b0100: ok = n;
            4'b0101: ok = !n;
            4'b0110: ok = v;
            4'b0111: ok = !v;
            4'b1000: ok = c && !z;
            4'b1001: ok = !c || z;
            4'b1010: ok = (n == v);
            4'b1011: ok = (n != v);
            4'b1100: ok = !z && (n == v);
            4'b1101: ok = z || (n != v);
            4'b1110: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [DATA_W-1:0] regs_r [REG_COUNT];

    logic [1:0] mode_s;
    logic [3:0] opcode_s;
    logic       s_bit_s;
    logic [3:0] rn_s;
    logic [3:0] rd_s;
    logic [3:0] rm_s;
    logic       is_str_s;
    logic       cond_ok_s;
    logic       wb_ok_s;

    logic [3:0] cmd_raw_s;
    logic       mr_raw_s;
    logic       mw_raw_s;
    logic       wb_raw_s;
    logic       s_raw_s;
    logic       b_raw_s;

    logic [DATA_W-1:0] rn_val_s;
    logic [DATA_W-1:0] rm_val_s;

    assign mode_s    = instruction[27:26];
    assign opcode_s  = instruction[24:21];
    assign s_bit_s   = instruction[20];
    assign rn_s      = instruction[19:16];
    assign rd_s      = instruction[15:12];
    assign rm_s      = instruction[3:0];
    assign is_str_s  = (mode_s == MODE_MEM) && !s_bit_s;
    assign cond_ok_s = cond_pass(instruction[31:28], status);

    // Writes to R15 (or beyond the stored registers) are dropped.
    assign wb_ok_s   = wb_en && (int'(wb_dest) < REG_COUNT);

    // Hazard-unit indications are raw decode, independent of stall/flush/cond.
    assign src1    = rn_s;
    assign src2    = is_str_s ? rd_s : rm_s;
    assign two_src = !instruction[25] || is_str_s;

    // Opcode/mode decode into raw control signals (before the condition gate).
    always_comb begin
        cmd_raw_s = 4'b0000;
        mr_raw_s  = 1'b0;
        mw_raw_s  = 1'b0;
        wb_raw_s  = 1'b0;
        s_raw_s   = 1'b0;
        b_raw_s   = 1'b0;
        case (mode_s)
            MODE_DP: begin
                case (opcode_s)
                    4'b1101: begin cmd_raw_s = 4'b0001; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b1111: begin cmd_raw_s = 4'b1001; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b0100: begin cmd_raw_s = 4'b0010; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b0101: begin cmd_raw_s = 4'b0011; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b0010: begin cmd_raw_s = 4'b0100; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b0110: begin cmd_raw_s = 4'b0101; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b0000: begin cmd_raw_s = 4'b0110; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b1100: begin cmd_raw_s = 4'b0111; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b0001: begin cmd_raw_s = 4'b1000; wb_raw_s = 1'b1; s_raw_s = s_bit_s; end
                    4'b1010: begin cmd_raw_s = 4'b0100; s_raw_s = s_bit_s; end
                    4'b1000: begin cmd_raw_s = 4'b0110; s_raw_s = s_bit_s; end
                    default: begin cmd_raw_s = 4'b0000; end
                endcase
            end
            MODE_MEM: begin
                cmd_raw_s = 4'b0010;
                if (s_bit_s) begin
                    mr_raw_s = 1'b1;
                    wb_raw_s = 1'b1;
                end else begin
                    mw_raw_s = 1'b1;
                end
            end
            MODE_BR: begin
                b_raw_s = 1'b1;
            end
            default: begin
                b_raw_s = 1'b0;
            end
        endcase
    end

`ifdef ID_NEGEDGE_WB_EN
    // Register file write on the falling edge; reads later in the cycle see it.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= '0;
        end else if (wb_ok_s) begin
            regs_r[wb_dest] <= wb_value;
        end
    end

    // Register read ports; R15 reads return the fetch PC.
    always_comb begin
        rn_val_s = '0;
        rm_val_s = '0;
        if (rn_s == 4'd15) rn_val_s = pc_in;
        else               rn_val_s = regs_r[rn_s];
        if (src2 == 4'd15) rm_val_s = pc_in;
        else               rm_val_s = regs_r[src2];
    end
`else
    // Register file write on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= '0;
        end else if (wb_ok_s) begin
            regs_r[wb_dest] <= wb_value;
        end
    end

    // Register read ports with same-cycle WB bypass; R15 reads return the fetch PC.
    always_comb begin
        rn_val_s = '0;
        rm_val_s = '0;
        if (rn_s == 4'd15)                      rn_val_s = pc_in;
        else if (wb_ok_s && (wb_dest == rn_s))  rn_val_s = wb_value;
        else                                    rn_val_s = regs_r[rn_s];
        if (src2 == 4'd15)                      rm_val_s = pc_in;
        else if (wb_ok_s && (wb_dest == src2))  rm_val_s = wb_value;
        else                                    rm_val_s = regs_r[src2];
    end
`endif

    // ID/EX pipeline register: flush clears everything, freeze clears controls only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out        <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            dest          <= 4'b0000;
            shift_operand <= 12'h000;
            imm           <= 1'b0;
            signed_imm_24 <= 24'h000000;
            exe_cmd       <= 4'b0000;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en_out     <= 1'b0;
            s_out         <= 1'b0;
            b_out         <= 1'b0;
        end else if (flush) begin
            pc_out        <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            dest          <= 4'b0000;
            shift_operand <= 12'h000;
            imm           <= 1'b0;
            signed_imm_24 <= 24'h000000;
            exe_cmd       <= 4'b0000;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en_out     <= 1'b0;
            s_out         <= 1'b0;
            b_out         <= 1'b0;
        end else begin
            pc_out        <= pc_in;
            val_rn        <= rn_val_s;
            val_rm        <= rm_val_s;
            dest          <= rd_s;
            shift_operand <= instruction[11:0];
            imm           <= instruction[25];
            signed_imm_24 <= instruction[23:0];
            if (freeze || !cond_ok_s) begin
                exe_cmd   <= 4'b0000;
                mem_r_en  <= 1'b0;
                mem_w_en  <= 1'b0;
                wb_en_out <= 1'b0;
                s_out     <= 1'b0;
                b_out     <= 1'b0;
            end else begin
                exe_cmd   <= cmd_raw_s;
                mem_r_en  <= mr_raw_s;
                mem_w_en  <= mw_raw_s;
                wb_en_out <= wb_raw_s;
                s_out     <= s_raw_s;
                b_out     <= b_raw_s;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode
// Self-checking bench for instruction_decode: directed sequences, a table of
// decode vectors and randomized cycles, all checked against a reference model
// built from the ARM decode rules and an array-based register file.
// -----------------------------------------------------------------------------
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  status;
    logic [31:0] pc_out;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic [11:0] shift_operand;
    logic        imm;
    logic [23:0] signed_imm_24;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en_out;
    logic        s_out;
    logic        b_out;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_decode dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .instruction(instruction),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .status(status),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .dest(dest),
        .shift_operand(shift_operand), .imm(imm), .signed_imm_24(signed_imm_24),
        .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en_out(wb_en_out), .s_out(s_out), .b_out(b_out),
        .src1(src1), .src2(src2), .two_src(two_src)
    );

    always #5 clk = ~clk;

    // Reference state: register file contents and data-processing opcode table.
    logic [31:0] mregs [15];
    logic [3:0]  op_cmd [16];
    logic        op_wb  [16];
    logic        op_ok  [16];

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  st;
        logic [8:0]  ctrl;   // {exe_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out}
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Even/odd condition pairs: odd codes are the inverse of the even one.
    function automatic logic m_cond(input logic [3:0] cc, input logic [3:0] st);
        logic n, z, c, v, r;
        {n, z, c, v} = st;
        if (cc == 4'hF) return 1'b0;
        if (cc == 4'hE) return 1'b1;
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b0;
        endcase
        return r ^ cc[0];
    endfunction

    function automatic logic [8:0] m_ctrl(input logic [31:0] w, input logic [3:0] st);
        logic [3:0] op;
        op = w[24:21];
        if (!m_cond(w[31:28], st)) return 9'd0;
        if (w[27:26] == 2'd0) begin
            if (op_ok[op]) return {op_cmd[op], 1'b0, 1'b0, op_wb[op], w[20], 1'b0};
            return 9'd0;
        end
        if (w[27:26] == 2'd1) begin
            if (w[20]) return {4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            return {4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        end
        if (w[27:26] == 2'd2) return 9'd1;
        return 9'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx, input logic [31:0] pc,
                                           input logic we, input logic [3:0] wd,
                                           input logic [31:0] wv);
        if (idx == 4'd15) return pc;
        if (we && wd == idx) return wv;
        return mregs[idx];
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {exe_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out};
    endfunction

    function automatic logic [31:0] nonzero_outputs();
        return {31'd0, |{pc_out, val_rn, val_rm, dest, shift_operand, imm,
                         signed_imm_24, dut_ctrl()}};
    endfunction

    // One decode cycle: drive, check combinational indications, clock, check ID/EX.
    task automatic apply(input logic [31:0] ins, input logic [3:0] st, input logic [31:0] pc,
                         input logic we, input logic [3:0] wd, input logic [31:0] wv,
                         input logic frz, input logic fl);
        logic        str;
        logic [3:0]  s2;
        logic [31:0] e_rn, e_rm;
        logic [8:0]  e_ctrl;
        instruction = ins; status = st; pc_in = pc;
        wb_en = we; wb_dest = wd; wb_value = wv; freeze = frz; flush = fl;
        str = (ins[27:26] == 2'd1) && !ins[20];
        s2  = str ? ins[15:12] : ins[3:0];
        #1;
        check("src1", {28'd0, src1}, {28'd0, ins[19:16]});
        check("src2", {28'd0, src2}, {28'd0, s2});
        check("two_src", {31'd0, two_src}, {31'd0, (!ins[25] || str)});
        e_rn   = m_read(ins[19:16], pc, we, wd, wv);
        e_rm   = m_read(s2, pc, we, wd, wv);
        e_ctrl = (fl || frz) ? 9'd0 : m_ctrl(ins, st);
        @(posedge clk);
        #1;
        if (we && wd != 4'd15) mregs[wd] = wv;
        check("ctrl", {23'd0, dut_ctrl()}, {23'd0, e_ctrl});
        if (fl) begin
            check("flush_zero", nonzero_outputs(), 32'd0);
        end else if (!frz) begin
            check("pc_out", pc_out, pc);
            check("val_rn", val_rn, e_rn);
            check("val_rm", val_rm, e_rm);
            check("fields", {dest, imm, shift_operand, signed_imm_24[14:0]},
                  {ins[15:12], ins[25], ins[11:0], ins[14:0]});
            check("imm24", {8'd0, signed_imm_24}, {8'd0, ins[23:0]});
        end
    endtask

    initial begin
        for (int i = 0; i < 15; i++) mregs[i] = 32'd0;
        for (int i = 0; i < 16; i++) begin op_ok[i] = 1'b0; op_cmd[i] = 4'd0; op_wb[i] = 1'b0; end
        op_ok[13] = 1'b1; op_cmd[13] = 4'd1; op_wb[13] = 1'b1;   // MOV
        op_ok[15] = 1'b1; op_cmd[15] = 4'd9; op_wb[15] = 1'b1;   // MVN
        op_ok[4]  = 1'b1; op_cmd[4]  = 4'd2; op_wb[4]  = 1'b1;   // ADD
        op_ok[5]  = 1'b1; op_cmd[5]  = 4'd3; op_wb[5]  = 1'b1;   // ADC
        op_ok[2]  = 1'b1; op_cmd[2]  = 4'd4; op_wb[2]  = 1'b1;   // SUB
        op_ok[6]  = 1'b1; op_cmd[6]  = 4'd5; op_wb[6]  = 1'b1;   // SBC
        op_ok[0]  = 1'b1; op_cmd[0]  = 4'd6; op_wb[0]  = 1'b1;   // AND
        op_ok[12] = 1'b1; op_cmd[12] = 4'd7; op_wb[12] = 1'b1;   // ORR
        op_ok[1]  = 1'b1; op_cmd[1]  = 4'd8; op_wb[1]  = 1'b1;   // EOR
        op_ok[10] = 1'b1; op_cmd[10] = 4'd4;                      // CMP
        op_ok[8]  = 1'b1; op_cmd[8]  = 4'd6;                      // TST

        vecs[0]  = '{32'hE3A01005, 4'b0000, 9'b0001_00100};  // MOV
        vecs[1]  = '{32'hE0823002, 4'b0000, 9'b0010_00100};  // ADD
        vecs[2]  = '{32'h1A000003, 4'b0100, 9'b0000_00000};  // BNE, Z=1
        vecs[3]  = '{32'h0A000003, 4'b0100, 9'b0000_00001};  // BEQ, Z=1
        vecs[4]  = '{32'hE5801000, 4'b0000, 9'b0010_01000};  // STR
        vecs[5]  = '{32'hE5901000, 4'b0000, 9'b0010_10100};  // LDR
        vecs[6]  = '{32'hE1520003, 4'b0000, 9'b0100_00010};  // CMP S
        vecs[7]  = '{32'hE1120003, 4'b0000, 9'b0110_00010};  // TST S
        vecs[8]  = '{32'hF3A01005, 4'b0000, 9'b0000_00000};  // cond never
        vecs[9]  = '{32'hE0610002, 4'b0000, 9'b0000_00000};  // unsupported opcode
        vecs[10] = '{32'hEC000000, 4'b0000, 9'b0000_00000};  // mode 11
        vecs[11] = '{32'hC3A01005, 4'b0000, 9'b0001_00100};  // GT true
        vecs[12] = '{32'hB3A01005, 4'b1000, 9'b0001_00100};  // LT true
        vecs[13] = '{32'h83A01005, 4'b0010, 9'b0001_00100};  // HI true
        vecs[14] = '{32'h83A01005, 4'b0110, 9'b0000_00000};  // HI false
        vecs[15] = '{32'hE3F01000, 4'b0000, 9'b1001_00110};  // MVNS

        rst = 1'b0; freeze = 1'b0; flush = 1'b0; pc_in = 32'd0; instruction = 32'd0;
        wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0; status = 4'd0;
        #2;
        check("reset_outputs", nonzero_outputs(), 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", nonzero_outputs(), 32'd0);
        rst = 1'b1;

        // MOV R1,#5 right after reset.
        apply(32'hE3A01005, 4'b0000, 32'd4, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("mov_cmd", {28'd0, exe_cmd}, 32'd1);
        check("mov_dest", {28'd0, dest}, 32'd1);
        check("mov_shop", {20'd0, shift_operand}, 32'h005);
        check("mov_pc", pc_out, 32'd4);

        // Write R2 = 0x10, then ADD R3,R2,R2.
        apply(32'h00000000, 4'b0000, 32'd8, 1'b1, 4'd2, 32'h10, 1'b0, 1'b0);
        apply(32'hE0823002, 4'b0000, 32'd12, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("add_rn", val_rn, 32'h10);
        check("add_rm", val_rm, 32'h10);

        // Same-cycle writeback bypass.
        apply(32'hE0823002, 4'b0000, 32'd16, 1'b1, 4'd2, 32'h55, 1'b0, 1'b0);
        check("bypass_rn", val_rn, 32'h55);

        // Write to R15 is ignored; R15 reads return pc_in.
        apply(32'h00000000, 4'b0000, 32'd20, 1'b1, 4'd15, 32'hDEAD, 1'b0, 1'b0);
        apply(32'hE08F300F, 4'b0000, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("r15_read", val_rn, 32'h1234);

        apply(32'h1A000003, 4'b0100, 32'd24, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("bne_b", {31'd0, b_out}, 32'd0);
        apply(32'h0A000003, 4'b0100, 32'd28, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("beq_b", {31'd0, b_out}, 32'd1);
        check("beq_imm", {8'd0, signed_imm_24}, 32'h000003);
        apply(32'hE5801000, 4'b0000, 32'd32, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("str_mw", {31'd0, mem_w_en}, 32'd1);
        check("str_src2", {28'd0, src2}, 32'd1);

        // Freeze on a valid ADD, then freeze together with flush.
        apply(32'hE0823002, 4'b0000, 32'd36, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        check("freeze_cmd", {28'd0, exe_cmd}, 32'd0);
        apply(32'hE0823002, 4'b0000, 32'd40, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1);

        // Table of decode vectors.
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].instr, vecs[i].st, 32'd100 + 32'(i), 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
            check($sformatf("vec%0d_ctrl", i), {23'd0, dut_ctrl()}, {23'd0, vecs[i].ctrl});
        end

        // Randomized cycles against the reference model.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            if ($urandom_range(0, 1) == 0) ins[27:26] = 2'b00;
            apply(ins, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // Reset mid-stream: outputs clear with no clock edge, registers read zero after.
        for (int i = 0; i < 15; i++)
            apply(32'h00000000, 4'b0000, 32'd0, 1'b1, 4'(i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        apply(32'hE3A01005, 4'b0000, 32'd44, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", nonzero_outputs(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 15; i++) mregs[i] = 32'd0;
        for (int i = 0; i < 15; i++) begin
            apply(32'hE0800000 | (32'(i) << 16) | 32'(i), 4'b0000, 32'd48, 1'b0, 4'd0, 32'd0,
                  1'b0, 1'b0);
            check($sformatf("cleared_r%0d", i), val_rn, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
